// File: rtl/md_pkg.sv
// Shared types and constants for the multiply/divide unit.
package md_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned MUL_CYCLES = 4;
  localparam int unsigned DIV_ITERS  = 32;
  localparam int unsigned CNT_W      = 5;

  typedef enum logic [2:0] {
    MD_NONE = 3'b000,
    MD_MULT = 3'b001,
    MD_DIV  = 3'b010,
    MD_MTHI = 3'b011,
    MD_MTLO = 3'b100
  } md_func_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_MUL    = 2'b01,
    S_DIV    = 2'b10,
    S_DIVFIX = 2'b11
  } md_state_e;

endpackage

// File: rtl/md_divider.sv
// Unsigned restoring divider: one quotient bit per clock, MSB first.
module md_divider
  import md_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            done
);

  localparam int unsigned ITER_W = $clog2(DIV_ITERS + 1);

  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   dvs;
  logic [ITER_W-1:0] cnt;
  logic [XLEN:0]     trial;
  logic [XLEN:0]     diff;

  // Shift in the next dividend bit and trial-subtract the divisor.
  always_comb begin
    trial = {rem, quo[XLEN-1]};
    diff  = trial - {1'b0, dvs};
  end

  // Iteration registers; a zero divisor skips the iterations entirely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem  <= '0;
      quo  <= '0;
      dvs  <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else if (start) begin
      rem  <= '0;
      quo  <= dividend;
      dvs  <= divisor;
      cnt  <= (divisor == '0) ? '0 : ITER_W'(DIV_ITERS);
      done <= (divisor == '0);
    end else if (cnt != '0) begin
      if (!diff[XLEN]) begin
        rem <= diff[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b1};
      end else begin
        rem <= trial[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b0};
      end
      cnt  <= cnt - ITER_W'(1);
      done <= (cnt == ITER_W'(1));
    end
  end

  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/md_unit.sv
// HI/LO multiply/divide unit: fixed-latency MULT, iterative DIV, MTHI/MTLO.
module md_unit
  import md_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            md_start,
  input  logic [2:0]      md_func,
  input  logic            md_sign,
  input  logic            ex_flush,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  output logic            busy,
  output logic            md_done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  md_state_e        state;
  md_state_e        state_next;
  md_func_e         func;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  op_a;
  logic [XLEN-1:0]  op_b;
  logic             sign_r;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;
  logic             accept_c;
  logic             mul_wr_c;
  logic             div_wr_c;
  logic             div_start_c;
  logic [XLEN-1:0]  mag_a_c;
  logic [XLEN-1:0]  mag_b_c;
  logic [2*XLEN-1:0] ext_a;
  logic [2*XLEN-1:0] ext_b;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]  div_q;
  logic [XLEN-1:0]  div_r;
  logic             div_done;

  assign func = md_func_e'(md_func);

  // State register; busy mirrors the registered state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != S_IDLE);
    end
  end

  // Accept decode and next-state logic.
  always_comb begin
    state_next  = state;
    accept_c    = 1'b0;
    mul_wr_c    = 1'b0;
    div_wr_c    = 1'b0;
    div_start_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (md_start && !ex_flush) begin
          case (func)
            MD_MULT: begin accept_c = 1'b1; state_next = S_MUL; end
            MD_DIV:  begin accept_c = 1'b1; div_start_c = 1'b1; state_next = S_DIV; end
            MD_MTHI, MD_MTLO: accept_c = 1'b1;
            default: accept_c = 1'b0;
          endcase
        end
      end
      S_MUL: begin
        if (cnt == '0) begin
          mul_wr_c   = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_DIV: begin
        if (cnt == '0) state_next = S_DIVFIX;
      end
      S_DIVFIX: begin
        div_wr_c   = div_done;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Operand magnitudes for the divider and extended operands for the product.
  always_comb begin
    mag_a_c = (md_sign && rs_val[XLEN-1]) ? -rs_val : rs_val;
    mag_b_c = (md_sign && rt_val[XLEN-1]) ? -rt_val : rt_val;
    ext_a   = sign_r ? {{XLEN{op_a[XLEN-1]}}, op_a} : {{XLEN{1'b0}}, op_a};
    ext_b   = sign_r ? {{XLEN{op_b[XLEN-1]}}, op_b} : {{XLEN{1'b0}}, op_b};
    product = ext_a * ext_b;
  end

  // Operand latches, sequencing counter and HI/LO write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      sign_r   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      md_done  <= 1'b0;
    end else begin
      md_done <= mul_wr_c | div_wr_c;
      if (accept_c) begin
        case (func)
          MD_MTHI: hi <= rs_val;
          MD_MTLO: lo <= rs_val;
          MD_MULT: begin
            op_a   <= rs_val;
            op_b   <= rt_val;
            sign_r <= md_sign;
            cnt    <= CNT_W'(MUL_CYCLES - 1);
          end
          MD_DIV: begin
            op_a     <= rs_val;
            neg_q    <= md_sign & (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
            neg_r    <= md_sign & rs_val[XLEN-1];
            div_zero <= (rt_val == '0);
            cnt      <= CNT_W'(DIV_ITERS - 1);
          end
          default: ;
        endcase
      end else if (state != S_IDLE && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (mul_wr_c) begin
        hi <= product[2*XLEN-1:XLEN];
        lo <= product[XLEN-1:0];
      end
      if (div_wr_c) begin
        if (div_zero) begin
          hi <= op_a;
          lo <= '1;
        end else begin
          hi <= neg_r ? -div_r : div_r;
          lo <= neg_q ? -div_q : div_q;
        end
      end
    end
  end

  md_divider u_divider (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start_c),
    .dividend  (mag_a_c),
    .divisor   (mag_b_c),
    .quotient  (div_q),
    .remainder (div_r),
    .done      (div_done)
  );

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit with a behavioural HI/LO reference model.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        md_start;
  logic [2:0]  md_func;
  logic        md_sign;
  logic        ex_flush;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        md_done;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl_hi = '0;
  logic [31:0] mdl_lo = '0;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          busy_cnt = 0;

  always #5 clk = ~clk;

  md_unit dut (
    .clk      (clk),
    .rst      (rst),
    .md_start (md_start),
    .md_func  (md_func),
    .md_sign  (md_sign),
    .ex_flush (ex_flush),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .busy     (busy),
    .md_done  (md_done),
    .hi       (hi),
    .lo       (lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference multiply: full 64-bit product of the two 32-bit operands.
  function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb_;
    longint unsigned ua, ub;
    if (s) begin
      sa = longint'($signed(a));
      sb_ = longint'($signed(b));
      return 64'(sa * sb_);
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  // Reference divide: returns {hi=remainder, lo=quotient}, truncating toward zero.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint q, r, sa, sb_;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = longint'($signed(a));
      sb_ = longint'($signed(b));
      q = sa / sb_;
      r = sa % sb_;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  // Monitor: hold check while busy, scoreboard pop and latency check on md_done.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (busy) begin
        busy_cnt++;
        check("hold_hilo", {hi, lo}, {mdl_hi, mdl_lo});
      end
      if (md_done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 64'(md_done), 64'd0);
        end else begin
          e = sb.pop_front();
          check("result_hi", 64'(hi), 64'(e.hi));
          check("result_lo", 64'(lo), 64'(e.lo));
          check("busy_cycles", 64'(busy_cnt), 64'(e.cycles));
          mdl_hi = e.hi;
          mdl_lo = e.lo;
        end
        busy_cnt = 0;
      end
    end
  end

  // Present one instruction for one cycle.
  task automatic drive(input logic [2:0] f, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic fl);
    @(posedge clk); #1;
    md_start = 1'b1; md_func = f; md_sign = s; rs_val = a; rt_val = b; ex_flush = fl;
    @(posedge clk); #1;
    md_start = 1'b0; ex_flush = 1'b0; md_func = 3'd0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check("drain_timeout", 64'(sb.size()), 64'd0);
    sb.delete();
    @(negedge clk);
  endtask

  // Issue an accepted operation and record its expected architectural effect.
  task automatic op(input logic [2:0] f, input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    drive(f, s, a, b, 1'b0);
    case (f)
      3'd1: begin r = ref_mul(s, a, b); sb.push_back('{r[63:32], r[31:0], 4}); wait_idle(); end
      3'd2: begin r = ref_div(s, a, b); sb.push_back('{r[63:32], r[31:0], 33}); wait_idle(); end
      3'd3: begin mdl_hi = a; @(negedge clk); check("mthi", {hi, lo}, {mdl_hi, mdl_lo}); end
      3'd4: begin mdl_lo = a; @(negedge clk); check("mtlo", {hi, lo}, {mdl_hi, mdl_lo}); end
      default: begin @(negedge clk); check("none_op", {hi, lo}, {mdl_hi, mdl_lo}); end
    endcase
  endtask

  initial begin
    logic [31:0] a, b;
    logic [2:0]  f;
    rst = 1'b1; md_start = 1'b0; md_func = 3'd0; md_sign = 1'b0; ex_flush = 1'b0;
    rs_val = '0; rt_val = '0;
    #12;
    check("reset_state", {32'(busy), 32'(md_done)}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk); rst = 1'b0;

    // Directed vectors.
    op(3'd1, 1'b0, 32'hFFFF_FFFF, 32'd2);
    op(3'd1, 1'b1, 32'hFFFF_FFFD, 32'd7);
    op(3'd1, 1'b0, 32'hFFFF_FFFD, 32'd7);
    op(3'd2, 1'b1, 32'hFFFF_FFF9, 32'd2);
    op(3'd2, 1'b0, 32'd100, 32'd7);
    op(3'd2, 1'b0, 32'd5, 32'd0);
    op(3'd2, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    op(3'd3, 1'b0, 32'hCAFE_0001, 32'd0);
    op(3'd4, 1'b0, 32'hBEEF_0002, 32'd0);
    op(3'd6, 1'b0, 32'h1111_1111, 32'd0);

    // Flushed MULT must not start.
    drive(3'd1, 1'b0, 32'd9, 32'd9, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("flush_busy", 64'(busy), 64'd0);
    end
    check("flush_hilo", {hi, lo}, {mdl_hi, mdl_lo});

    // MTHI presented while a MULT is in flight is ignored.
    drive(3'd1, 1'b1, 32'd12345, 32'hFFFF_FF00, 1'b0);
    a = 32'd12345; b = 32'hFFFF_FF00;
    sb.push_back('{ref_mul(1'b1, a, b) >> 32, ref_mul(1'b1, a, b) & 64'hFFFF_FFFF, 4});
    @(posedge clk); #1;
    md_start = 1'b1; md_func = 3'd3; rs_val = 32'h1234;
    @(posedge clk); #1;
    md_start = 1'b0; md_func = 3'd0;
    wait_idle();
    check("mthi_busy_ignored", {hi, lo}, {mdl_hi, mdl_lo});

    // Reset in the middle of a divide aborts it.
    drive(3'd2, 1'b0, 32'd1000, 32'd3, 1'b0);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(md_done), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    mdl_hi = '0; mdl_lo = '0;
    @(negedge clk); #1 rst = 1'b0;
    op(3'd4, 1'b0, 32'hABCD, 32'd0);
    repeat (40) @(negedge clk);
    check("abort_no_update", {hi, lo}, {32'd0, 32'hABCD});

    // Randomized mix checked against the reference model.
    for (int n = 0; n < 30; n++) begin
      f = 3'($urandom_range(1, 4));
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      op(f, 1'($urandom_range(0, 1)), a, b);
    end

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports named clk and rst.
REQ-002 clk  in  1  pipeline clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 md_start  in  1  EX stage holds an MD-class instruction this cycle.
REQ-005 md_func  in  3  operation code: 000 NONE, 001 MULT, 010 DIV, 011 MTHI, 100 MTLO, others NONE (from EX_CTRL.MDFunc).
REQ-006 md_sign  in  1  1 = signed MULT/DIV, 0 = unsigned (EX_CTRL.MDSign).
REQ-007 ex_flush  in  1  EX instruction is squashed this cycle.
REQ-008 rs_val  in  32  forwarded rs operand: multiplicand, dividend, or MTHI/MTLO source.
REQ-009 rt_val  in  32  forwarded rt operand: multiplier or divisor.
REQ-010 busy  out  1  MULT/DIV in flight; the stall logic SHALL hold ID while busy and ID holds MFHI/MFLO/MD-class.
REQ-011 md_done  out  1  one-cycle pulse in the first cycle the new HI/LO are visible.
REQ-012 hi, lo  out  32 each  architectural HI and LO registers, read by the EX MFHI/MFLO path.

Function
REQ-013 Accept condition: md_start && !ex_flush && !busy && md_func is a defined non-NONE code; otherwise no state SHALL change.
REQ-014 States: IDLE, MUL, DIV, DIVFIX; busy SHALL equal (state != IDLE).
REQ-015 MTHI/MTLO: on accept, hi (resp. lo) SHALL take rs_val at that edge; state stays IDLE; md_done SHALL not pulse.
REQ-016 MULT: on accept, operands latched, state -> MUL, counter = 3; each edge decrements; at the edge with counter 0, {hi,lo} SHALL take the 64-bit product and state -> IDLE; busy high exactly 4 cycles.
REQ-017 MULT signed SHALL sign-extend both operands to 64 bits; unsigned SHALL zero-extend.
REQ-018 DIV: on accept, magnitudes latched (absolute values if md_sign), state -> DIV, 32 restoring iterations, one quotient bit per edge, MSB first; then DIVFIX one edge applying signs, writing hi=remainder, lo=quotient, state -> IDLE; busy high exactly 33 cycles.
REQ-019 Signed DIV: quotient negative iff operand signs differ; remainder SHALL carry the dividend's sign (truncating division).
REQ-020 Divide by zero: no iterations performed; at DIVFIX lo SHALL be 32'hFFFFFFFF and hi SHALL be rs_val; busy duration unchanged (33 cycles).
REQ-021 Signed 32'h80000000 / 32'hFFFFFFFF SHALL yield lo=32'h80000000, hi=0.
REQ-022 md_done SHALL be high exactly in the cycle following the hi/lo-writing edge of MULT or DIV.
REQ-023 md_start while busy SHALL be ignored and the in-flight operation SHALL complete unaffected; ex_flush SHALL NOT cancel an already-accepted operation.
REQ-024 hi/lo SHALL hold their values throughout busy; the old values remain readable until the writing edge.

Reset
REQ-025 On rst: state = IDLE, counter = 0, hi = 0, lo = 0, busy = 0, md_done = 0, operand registers = 0, immediately and independent of clk.
REQ-026 rst asserted mid-MULT/DIV SHALL abort the operation with no hi/lo update after release; first accept SHALL be possible on the first edge after rst deasserts.

Structure
REQ-027 Shared package md_pkg SHALL hold the md_func enum (NONE, MULT, DIV, MTHI, MTLO), the 2-bit state enum, and constants MUL_CYCLES = 4, DIV_ITERS = 32.
REQ-028 The iterative restoring core SHALL be a sub-module md_divider (start, dividend, divisor magnitudes in; quotient, remainder, done out); sign handling and the MULT path stay in md_unit.

Verification
REQ-029 Unsigned MULT 32'hFFFFFFFF x 2 -> busy 4 cycles, then hi=1, lo=32'hFFFFFFFE, md_done 1 cycle.
REQ-030 Signed MULT -3 x 7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; unsigned same operands -> hi=6, lo=32'hFFFFFFEB.
REQ-031 Signed DIV -7 / 2 -> busy 33 cycles, lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; unsigned 100 / 7 -> lo=14, hi=2.
REQ-032 DIV 5 / 0 -> lo=32'hFFFFFFFF, hi=5 after 33 cycles; signed 32'h80000000 / -1 -> lo=32'h80000000, hi=0.
REQ-033 MULT issued with ex_flush=1 -> busy stays 0, hi/lo unchanged; MTHI 32'h1234 during busy -> ignored.
REQ-034 rst pulse at DIV iteration 10 -> hi=lo=0, busy=0 immediately, no md_done; MTLO 32'hABCD on next edge -> lo=32'hABCD.
